// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, mode codes and BCD helpers for the stopwatch sequencer
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } sw_state_e;

   localparam logic [1:0] MODE_UP_ZERO   = 2'b00;
   localparam logic [1:0] MODE_UP_PRESET = 2'b01;
   localparam logic [1:0] MODE_DN_MAX    = 2'b10;
   localparam logic [1:0] MODE_DN_PRESET = 2'b11;

   localparam logic [15:0] BCD_ZERO = 16'h0000;
   localparam logic [15:0] BCD_MAX  = 16'h9999;

   function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   // Preset modes load whole seconds only; hundredths always start at zero.
   function automatic logic [15:0] latch_value(input logic [1:0] mode, input logic [7:0] preset);
      logic [15:0] v;
      case (mode)
         MODE_UP_ZERO:   v = BCD_ZERO;
         MODE_DN_MAX:    v = BCD_MAX;
         MODE_UP_PRESET,
         MODE_DN_PRESET: v = {clamp_nibble(preset[7:4]), clamp_nibble(preset[3:0]), 8'h00};
         default:        v = BCD_ZERO;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchroniser, optional stability filter (SW_CTRL_DEBOUNCE_EN) and rising-edge pulse
module btn_conditioner #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_i,
   output logic ev_o
);

`ifdef SW_CTRL_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif
   localparam bit USE_DB = DB_EN && (DB_CYCLES > 0);

   logic sync1_q, sync2_q, level_prev_q;
   logic level;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         level_prev_q <= 1'b0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         level_prev_q <= level;
      end
   end

   if (USE_DB) begin : g_debounce
      localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
      logic [CW-1:0] cnt_q;
      logic          level_q;

      // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
         end else if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
      assign level = level_q;
   end else begin : g_direct
      assign level = sync2_q;
   end

   assign ev_o = level & ~level_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencer: buttons, mode latch, IDLE/RUN/PAUSE/DONE FSM, tick prescaler (SW_CTRL_DEBOUNCE_EN)
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 1_000_000,
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_start,
   input  logic        btn_clear,
   input  logic [1:0]  mode_sw,
   input  logic [7:0]  preset_sw,
   input  logic        at_limit,
   output logic        tick,
   output logic        count_up,
   output logic        load,
   output logic [15:0] load_val,
   output logic        running,
   output logic        done
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   sw_state_e     state_q;
   logic [PW-1:0] presc_q;
   logic          init_pend_q;
   logic          load_q;
   logic          count_up_q;
   logic [15:0]   load_val_q;

   logic start_ev, clear_ev, latch, presc_wrap;

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_start),
      .ev_o    (start_ev)
   );

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_clear),
      .ev_o    (clear_ev)
   );

   assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
   assign latch      = clear_ev | init_pend_q;

   // clear_ev overrides everything; otherwise the prescaler only advances while in RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         init_pend_q <= 1'b1;
         load_q      <= 1'b0;
         count_up_q  <= 1'b1;
         load_val_q  <= BCD_ZERO;
      end else begin
         init_pend_q <= 1'b0;
         load_q      <= latch;
         if (latch) begin
            count_up_q <= ~mode_sw[1];
            load_val_q <= latch_value(mode_sw, preset_sw);
         end
         if (clear_ev) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
         end else begin
            if (state_q == ST_RUN) begin
               presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            end
            case (state_q)
               ST_IDLE: begin
                  if (start_ev) begin
                     if (at_limit) begin
                        state_q <= ST_DONE;
                        presc_q <= '0;
                     end else begin
                        state_q <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  if (start_ev) begin
                     state_q <= ST_PAUSE;
                  end else if (at_limit) begin
                     state_q <= ST_DONE;
                     presc_q <= '0;
                  end
               end
               ST_PAUSE: begin
                  if (start_ev) state_q <= ST_RUN;
               end
               default: ;
            endcase
         end
      end
   end

   assign tick     = (state_q == ST_RUN) && presc_wrap && !at_limit;
   assign load     = load_q;
   assign count_up = count_up_q;
   assign load_val = load_val_q;
   assign running  = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);

endmodule
